// File: rtl/dmem_pkg.sv
// Shared types and constants for the latency-pipelined data-memory responder.
package dmem_pkg;
  localparam int WORD_W      = 16;
  localparam int LATENCY_MAX = 8;
  // Widest byte address a pipeline entry can carry.
  localparam int ADDR_MAX    = 16;

  typedef struct packed {
    logic                valid;
    logic [WORD_W-1:0]   data;
    logic [ADDR_MAX-1:0] addr;
  } dmem_entry_t;
endpackage

// File: rtl/dmem_pipe_stage.sv
// One read-pipeline entry: loads when not held, fully cleared by async reset.
module dmem_pipe_stage
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  dmem_entry_t d_i,
  output dmem_entry_t q_o
);
  dmem_entry_t entry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       entry_q <= '0;
    else if (!hold_i) entry_q <= d_i;
  end

  assign q_o = entry_q;
endmodule

// File: rtl/dmem_resp.sv
// Data memory with write-at-accept stores and fixed-latency, stallable in-order load responses.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [WORD_W-1:0] resp_data_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic              busy_o
);
  localparam int DEPTH = 2 ** (ADDR_W - 1);

  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-2:0]  widx;
  logic               stall, accept;
  dmem_entry_t        new_entry;
  dmem_entry_t        stg_d [LATENCY];
  dmem_entry_t        stg_q [LATENCY];
  logic [LATENCY-1:0] vld;

  assign widx        = req_addr_i[ADDR_W-1:1];
  // A presented response that is not taken freezes the whole pipe.
  assign stall       = resp_valid_o && !resp_ready_i;
  assign req_ready_o = !stall;
  assign accept      = req_valid_i && req_ready_o;

  // Array is deliberately unreset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && req_wr_i) mem_q[widx] <= req_wdata_i;
  end

  always_comb begin
    new_entry       = '0;
    new_entry.valid = accept && !req_wr_i;
    new_entry.data  = mem_q[widx];
    new_entry.addr  = ADDR_MAX'(req_addr_i);
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stg_d[i] = new_entry;
    end else begin : g_tail
      assign stg_d[i] = stg_q[i-1];
    end

    dmem_pipe_stage u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold_i (stall),
      .d_i    (stg_d[i]),
      .q_o    (stg_q[i])
    );

    assign vld[i] = stg_q[i].valid;
  end

  assign resp_valid_o = stg_q[LATENCY-1].valid;
  assign resp_data_o  = stg_q[LATENCY-1].data;
  assign resp_addr_o  = stg_q[LATENCY-1].addr[ADDR_W-1:0];
  assign busy_o       = |vld;
endmodule
